block_code_corr_decoder: RTL and testbench

//  Parametrised soft-decision block-code correlator for received chip streams.
//  - Accepts signed soft chips on AXI4-Stream and correlates each run of L chips against the Barker code selected by code_length.
//  - Emits one signed correlation sum per code word, NUM_SYMBOLS words per frame.
//  - Adds output backpressure, per-frame code-length switching and frame-alignment checking.

---
 rtl/block_code_pkg.sv | 44 ++++
 rtl/block_code_out_fifo.sv | 63 ++++++
 rtl/block_code_corr_decoder.sv | 142 ++++++++++++++
 tb/tb_block_code_corr_decoder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_code_pkg.sv
// Shared definitions for the Barker-code correlator: code table, code helpers
// and the frame FSM state type.
package block_code_pkg;

   localparam int BARKER_W = 13;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DISCARD
   } state_e;

   // Barker sequences left-justified, chip 0 in the MSB; a 1 bit means a +1 chip.
   function automatic logic [BARKER_W-1:0] barker_row(input logic [3:0] len);
      logic [BARKER_W-1:0] row;
      case (len)
         4'd2:    row = 13'b10_00000000000;
         4'd3:    row = 13'b110_0000000000;
         4'd4:    row = 13'b1101_000000000;
         4'd5:    row = 13'b11101_00000000;
         4'd7:    row = 13'b1110010_000000;
         4'd11:   row = 13'b11100010010_00;
         4'd13:   row = 13'b1111100110101;
         default: row = '0;
      endcase
      return row;
   endfunction

   function automatic logic code_supported(input logic [7:0] len);
      logic ok;
      case (len)
         8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd11, 8'd13: ok = 1'b1;
         default:                                    ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic code_bit(input logic [3:0] len, input logic [3:0] idx);
      logic [BARKER_W-1:0] row;
      row = barker_row(len) << idx;
      return row[BARKER_W-1];
   endfunction

endpackage

// File: rtl/block_code_out_fifo.sv
// Synchronous word FIFO with a registered output stage; the output register
// counts toward capacity, so full means DEPTH words are held in total.
module block_code_out_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         last_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W:0]    mem [DEPTH];
   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [PW:0]   count_q;
   logic [PW:0]   occupancy;
   logic          outValid_q;
   logic [W-1:0]  outData_q;
   logic          outLast_q;
   logic          load;

   assign occupancy = count_q + {{PW{1'b0}}, outValid_q};
   assign full_o    = (occupancy == (PW+1)'(DEPTH));
   assign load      = (count_q != '0) && (!outValid_q || pop_i);
   assign valid_o   = outValid_q;
   assign data_o    = outData_q;
   assign last_o    = outLast_q;

   always_ff @(posedge clk) begin
      if (push_i) mem[wrPtr_q] <= {last_i, data_i};
   end

   // The output register refills from storage whenever it is empty or being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outLast_q  <= 1'b0;
      end else begin
         if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
         if (load) begin
            {outLast_q, outData_q} <= mem[rdPtr_q];
            rdPtr_q    <= rdPtr_q + 1'b1;
            outValid_q <= 1'b1;
         end else if (pop_i) begin
            outValid_q <= 1'b0;
         end
         count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, load};
      end
   end

endmodule

// File: rtl/block_code_corr_decoder.sv
// Soft-decision Barker correlator: one signed sum per code word, NUM_SYMBOLS per frame.
// Define BLOCK_CODE_FRAME_CHECK_EN to enable tlast-based frame alignment checking.
module block_code_corr_decoder
   import block_code_pkg::*;
#(
   parameter int  DATA_WIDTH   = 4,
   parameter int  NUM_SYMBOLS  = 20,
   parameter int  MAX_CODE_LEN = 13,
   parameter int  FIFO_DEPTH   = 4,
   localparam int ACC_W        = DATA_WIDTH + $clog2(MAX_CODE_LEN) + 1
) (
   input  logic                  clk,
   input  logic                  s_axis_aresetn,
   input  logic [7:0]            code_length,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [ACC_W-1:0]      m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  frame_err
);

   localparam int WCW = $clog2(NUM_SYMBOLS);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_SYMBOLS - 1);

   state_e                   state_q;
   logic [3:0]               len_q, chipCnt_q;
   logic [WCW-1:0]           wordCnt_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     readyEn_q, frameErr_q;

   logic [3:0]               lenSel, chipIdx;
   logic [WCW-1:0]           wordIdx;
   logic signed [ACC_W-1:0]  accBase, chipExt, accSum;
   logic                     badLen, wordDone, frameDone, earlyLast, missingLast;
   logic                     wordPush, fire, push, pushLast, fifoFull;

   // In IDLE the incoming chip is chip 0 of a new frame using the freshly sampled length.
   always_comb begin
      lenSel  = len_q;
      chipIdx = chipCnt_q;
      wordIdx = wordCnt_q;
      accBase = acc_q;
      badLen  = 1'b0;
      if (state_q == IDLE) begin
         badLen  = !code_supported(code_length);
         lenSel  = badLen ? 4'd13 : code_length[3:0];
         chipIdx = '0;
         wordIdx = '0;
         accBase = '0;
      end
      chipExt   = {{(ACC_W-DATA_WIDTH){s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
      accSum    = code_bit(lenSel, chipIdx) ? accBase + chipExt : accBase - chipExt;
      wordDone  = (chipIdx == lenSel - 4'd1);
      frameDone = wordDone && (wordIdx == LAST_WORD);
`ifdef BLOCK_CODE_FRAME_CHECK_EN
      earlyLast   = s_axis_tlast && !frameDone && (state_q != DISCARD);
      missingLast = frameDone && !s_axis_tlast;
`else
      earlyLast   = 1'b0;
      missingLast = 1'b0;
`endif
   end

`ifndef BLOCK_CODE_FRAME_CHECK_EN
   logic unusedTlast;
   assign unusedTlast = s_axis_tlast;
`endif

   // Only a chip that must push into a full FIFO is held off.
   assign wordPush      = (state_q != DISCARD) && (wordDone || earlyLast);
   assign s_axis_tready = readyEn_q && !(wordPush && fifoFull);
   assign fire          = s_axis_tvalid && s_axis_tready;
   assign push          = fire && wordPush;
   assign pushLast      = frameDone || earlyLast;
   assign frame_err     = frameErr_q;

   always_ff @(posedge clk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         state_q    <= IDLE;
         len_q      <= 4'd13;
         chipCnt_q  <= '0;
         wordCnt_q  <= '0;
         acc_q      <= '0;
         readyEn_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         readyEn_q  <= 1'b1;
         frameErr_q <= 1'b0;
         if (fire) begin
            case (state_q)
               IDLE, RUN: begin
                  len_q      <= lenSel;
                  frameErr_q <= badLen || earlyLast || missingLast;
                  if (frameDone || earlyLast) begin
                     state_q   <= missingLast ? DISCARD : IDLE;
                     chipCnt_q <= '0;
                     wordCnt_q <= '0;
                     acc_q     <= '0;
                  end else if (wordDone) begin
                     state_q   <= RUN;
                     chipCnt_q <= '0;
                     wordCnt_q <= wordIdx + 1'b1;
                     acc_q     <= '0;
                  end else begin
                     state_q   <= RUN;
                     chipCnt_q <= chipIdx + 4'd1;
                     acc_q     <= accSum;
                  end
               end
               default: begin
`ifdef BLOCK_CODE_FRAME_CHECK_EN
                  if (s_axis_tlast) state_q <= IDLE;
`else
                  state_q <= IDLE;
`endif
               end
            endcase
         end
      end
   end

   block_code_out_fifo #(
      .W     (ACC_W),
      .DEPTH (FIFO_DEPTH)
   ) outFifo (
      .clk     (clk),
      .rst_n   (s_axis_aresetn),
      .push_i  (push),
      .data_i  (accSum),
      .last_i  (pushLast),
      .pop_i   (m_axis_tready),
      .full_o  (fifoFull),
      .valid_o (m_axis_tvalid),
      .data_o  (m_axis_tdata),
      .last_o  (m_axis_tlast)
   );

endmodule

// File: tb/tb_block_code_corr_decoder.sv
// Scoreboard bench for block_code_corr_decoder: a string-based Barker model feeds
// an expected-word queue that an independent output monitor drains and checks.
module tb_block_code_corr_decoder;

   localparam int DW  = 4;
   localparam int NS  = 20;
   localparam int MCL = 13;
   localparam int FD  = 4;
   localparam int AW  = DW + $clog2(MCL) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    code_length;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid, s_tready, s_tlast;
   logic [AW-1:0] m_tdata;
   logic          m_tvalid, m_tready, m_tlast;
   logic          frame_err;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t          expQ[$];
   exp_t          monE;
   int            checks = 0;
   int            failures = 0;
   int            errSeen = 0;
   int            expErr = 0;
   int            readyMode = 0;
   int            stallCycles = 0;
   bit            sawReadyLow = 0;
   bit            prevStall = 0;
   logic [AW-1:0] prevData;
   logic          prevLast;

   block_code_corr_decoder #(
      .DATA_WIDTH   (DW),
      .NUM_SYMBOLS  (NS),
      .MAX_CODE_LEN (MCL),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk            (clk),
      .s_axis_aresetn (rst_n),
      .code_length    (code_length),
      .s_axis_tdata   (s_tdata),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tready  (s_tready),
      .s_axis_tlast   (s_tlast),
      .m_axis_tdata   (m_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .m_axis_tlast   (m_tlast),
      .frame_err      (frame_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int barkerSign(input int len, input int i);
      string s;
      case (len)
         2:       s = "+-";
         3:       s = "++-";
         4:       s = "++-+";
         5:       s = "+++-+";
         7:       s = "+++--+-";
         11:      s = "+++---+--+-";
         default: s = "+++++--++-+-+";
      endcase
      return (s[i] == "+") ? 1 : -1;
   endfunction

   function automatic bit lengthOk(input int len);
      return len inside {2, 3, 4, 5, 7, 11, 13};
   endfunction

   // Present one chip and hold it until the DUT accepts it.
   task automatic sendChip(input int v, input bit last);
      int waitCycles;
      bit hs;
      waitCycles = 0;
      s_tdata  = v[DW-1:0];
      s_tlast  = last;
      s_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         hs = s_tready;
         if (!hs) stallCycles++;
         @(posedge clk);
         #1;
         if (hs) break;
         waitCycles++;
         if (waitCycles > 500) begin
            checks++;
            failures++;
            $display("[TB] FAIL chip handshake timeout: got no ready in %0d cycles, expected ready", waitCycles);
            break;
         end
      end
   endtask

   // Build a frame, predict its words from the Barker strings, then drive it.
   // nChips <= 0 sends exactly one full frame with tlast on its final chip.
   task automatic applyStimulus(input int codeLen, input int mode, input int amp,
                                input int nChips, input int bubblePct);
      int effL, total, n, used, sum, v;
      int chips[$];
      effL  = lengthOk(codeLen) ? codeLen : 13;
      total = effL * NS;
      n     = (nChips <= 0) ? total : nChips;
      for (int i = 0; i < n; i++) begin
         if (mode == 0) v = int'($urandom_range(0, 15)) - 8;
         else           v = barkerSign(effL, i % effL) * amp;
         chips.push_back(v);
      end
`ifdef BLOCK_CODE_FRAME_CHECK_EN
      used = (n < total) ? n : total;
      if (n != total) expErr++;
`else
      used = total;
`endif
      if (!lengthOk(codeLen)) expErr++;
      for (int w = 0; w * effL < used; w++) begin
         sum = 0;
         for (int c = 0; c < effL && (w * effL + c) < used; c++)
            sum += chips[w * effL + c] * barkerSign(effL, c);
         expQ.push_back('{data: sum, last: ((w + 1) * effL >= used)});
      end
      code_length = codeLen[7:0];
      for (int i = 0; i < n; i++) begin
         if (int'($urandom_range(0, 99)) < bubblePct) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         sendChip(chips[i], i == n - 1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      readyMode = 0;
      while (expQ.size() != 0 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      checkOutput("words outstanding after drain", expQ.size(), 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("frame_err pulse count", errSeen, expErr);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " m_axis_tvalid"}, m_tvalid, 0);
      checkOutput({tag, " m_axis_tdata"}, m_tdata, 0);
      checkOutput({tag, " m_axis_tlast"}, m_tlast, 0);
      checkOutput({tag, " frame_err"}, frame_err, 0);
      checkOutput({tag, " s_axis_tready"}, s_tready, 0);
   endtask

   // Downstream ready generator: 0 always ready, 1 random, 2 stalled.
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Output monitor: pops the scoreboard on every accepted word and checks stall stability.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevStall = 0;
         end else begin
            if (frame_err) errSeen++;
            if (!s_tready) sawReadyLow = 1;
            if (prevStall) begin
               checks++;
               if (m_tvalid !== 1'b1 || m_tdata !== prevData || m_tlast !== prevLast) begin
                  failures++;
                  $display("[TB] FAIL stall stability: got valid=%0b data=%0d last=%0b, expected valid=1 data=%0d last=%0b",
                           m_tvalid, $signed(m_tdata), m_tlast, $signed(prevData), prevLast);
               end
            end
            if (m_tvalid && m_tready) begin
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected word: got %0d, expected no output", $signed(m_tdata));
               end else begin
                  monE = expQ.pop_front();
                  checkOutput("word data", $signed(m_tdata), monE.data);
                  checkOutput("word tlast", m_tlast, monE.last);
               end
            end
            prevStall = m_tvalid && !m_tready;
            prevData  = m_tdata;
            prevLast  = m_tlast;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global timeout: got no end of test, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      int lens[7];
      int hsSeen, lat, pick;
      lens = '{2, 3, 4, 5, 7, 11, 13};
      rst_n       = 1'b0;
      s_tvalid    = 1'b0;
      s_tlast     = 1'b0;
      s_tdata     = '0;
      code_length = 8'd13;
      #2;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("tready before first edge", s_tready, 0);
      @(posedge clk);
      #1;
      checkOutput("tready after release", s_tready, 1);
      readyMode = 0;

      $display("[TB] first-word latency, L=2");
      hsSeen = 0;
      lat    = -1;
      fork
         applyStimulus(2, 1, 5, 0, 0);
         begin
            for (int c = 0; c < 50 && hsSeen < 2; c++) begin
               @(negedge clk);
               if (s_tvalid && s_tready) hsSeen++;
            end
            for (int c = 1; c <= 10; c++) begin
               @(negedge clk);
               if (m_tvalid) begin
                  lat = c;
                  break;
               end
            end
         end
      join
      checkOutput("first word latency", lat, 2);
      drain();

      $display("[TB] matched and inverted L=13");
      applyStimulus(13, 1, 7, 0, 0);
      drain();
      applyStimulus(13, 1, -7, 0, 0);
      drain();

      $display("[TB] back-to-back L=13 then L=5");
      stallCycles = 0;
      applyStimulus(13, 1, 7, 0, 0);
      applyStimulus(5, 1, 3, 0, 0);
      checkOutput("input stalls on back-to-back frames", stallCycles, 0);
      drain();

      $display("[TB] downstream stall mid-frame");
      sawReadyLow = 0;
      fork
         applyStimulus(13, 0, 0, 0, 0);
         begin
            repeat (20) @(posedge clk);
            #1 readyMode = 2;
            repeat (80) @(posedge clk);
            #1 readyMode = 0;
         end
      join
      checkOutput("tready dropped with fifo full", sawReadyLow, 1);
      drain();

      $display("[TB] unsupported length 6");
      readyMode = 1;
      applyStimulus(6, 1, 7, 0, 0);
      drain();

      $display("[TB] random frames");
      for (int k = 0; k < 6; k++) begin
         readyMode = 1;
         pick = (k == 3) ? 9 : lens[$urandom_range(0, 6)];
         applyStimulus(pick, 0, 0, 0, 20);
      end
      drain();

`ifdef BLOCK_CODE_FRAME_CHECK_EN
      $display("[TB] frame alignment checks");
      applyStimulus(13, 1, 7, 100, 0);
      drain();
      readyMode = 1;
      applyStimulus(13, 0, 0, 275, 10);
      applyStimulus(3, 0, 0, 2, 0);
      applyStimulus(7, 0, 0, 0, 0);
      drain();
`endif

      $display("[TB] reset mid-frame");
      readyMode   = 2;
      code_length = 8'd13;
      for (int i = 0; i < 30; i++) sendChip(int'($urandom_range(0, 15)) - 8, 1'b0);
      s_tvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid-frame reset");
      expQ.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("tready before first edge after reset", s_tready, 0);
      @(posedge clk);
      #1;
      checkOutput("tready after reset release", s_tready, 1);
      readyMode = 0;
      applyStimulus(7, 0, 0, 0, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
